// File: rtl/rvv_rob_param_pkg.sv
// Shared types and helpers for the parametrised RVV reorder buffer.
package rvv_rob_param_pkg;

  // Per-entry status bits. The info and data payloads are sized by the
  // instantiating module's parameters and are held in arrays beside this struct.
  typedef struct packed {
    logic valid;
    logic done;
    logic trap;
    logic wvalid;
    logic sat;
  } rob_flags_t;

  localparam int FLAGS_W = $bits(rob_flags_t);

  // Entry index width for a given depth; never less than one bit.
  function automatic int rob_ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Number of set bits; used for pointer advance on dispatch and retire.
  function automatic int unsigned popcount(input logic [31:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < 32; i++) n = n + 32'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/rvv_rob_age_rotate.sv
// Rotates a DEPTH-entry array so that element 0 is the entry at the read pointer.
module rvv_rob_age_rotate
  import rvv_rob_param_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int W     = 1,
  localparam int PTR_W = rob_ptr_w(DEPTH)
) (
  input  logic [DEPTH*W-1:0] din,
  input  logic [PTR_W-1:0]   shift,
  output logic [DEPTH*W-1:0] dout
);

  // Age slot j reads physical entry (shift + j) mod DEPTH.
  always_comb begin
    logic [PTR_W-1:0] src;
    dout = '0;
    src  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      src = PTR_W'(j) + shift;
      dout[j*W +: W] = din[int'(src)*W +: W];
    end
  end

endmodule

// File: rtl/rvv_backend_rob_param.sv
// Parametrised reorder buffer: in-order allocate, out-of-order writeback,
// in-order multi-slot retire, trap flush, and an age-ordered bypass view.
module rvv_backend_rob_param
  import rvv_rob_param_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int NUM_DP = 2,
  parameter int NUM_WB = 9,
  parameter int NUM_RT = 4,
  parameter int DATA_W = 128,
  parameter int INFO_W = 32,
  localparam int PTR_W = rob_ptr_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_DP-1:0]        dp_valid,
  input  logic [NUM_DP*INFO_W-1:0] dp_info,
  output logic [NUM_DP-1:0]        dp_ready,
  output logic [NUM_DP*PTR_W-1:0]  dp_index,
  input  logic [NUM_WB-1:0]        wb_valid,
  input  logic [NUM_WB*PTR_W-1:0]  wb_entry,
  input  logic [NUM_WB-1:0]        wb_wvalid,
  input  logic [NUM_WB*DATA_W-1:0] wb_data,
  input  logic [NUM_WB-1:0]        wb_sat,
  output logic [NUM_RT-1:0]        rt_valid,
  input  logic [NUM_RT-1:0]        rt_ready,
  output logic [NUM_RT*INFO_W-1:0] rt_info,
  output logic [NUM_RT-1:0]        rt_wvalid,
  output logic [NUM_RT*DATA_W-1:0] rt_data,
  output logic [NUM_RT-1:0]        rt_sat,
  output logic [NUM_RT-1:0]        rt_trap,
  input  logic                     trap_valid,
  input  logic [PTR_W-1:0]         trap_entry,
  output logic                     flush,
  output logic [DEPTH-1:0]         byp_valid,
  output logic [DEPTH-1:0]         byp_done,
  output logic [DEPTH*INFO_W-1:0]  byp_info,
  output logic [DEPTH*DATA_W-1:0]  byp_data,
  output logic [PTR_W:0]           count,
  output logic                     empty,
  output logic                     full,
  output logic                     err_stale_wb
);

  localparam int ENTRY_W = FLAGS_W + INFO_W + DATA_W;

  rob_flags_t        flags_q [DEPTH];
  logic [INFO_W-1:0] info_q  [DEPTH];
  logic [DATA_W-1:0] data_q  [DEPTH];
  logic [PTR_W:0]    wptr_q, rptr_q;
  logic              err_q;

  logic [DEPTH*ENTRY_W-1:0] flat, rot;
  rob_flags_t        age_flags [DEPTH];
  logic [INFO_W-1:0] age_info  [DEPTH];
  logic [DATA_W-1:0] age_data  [DEPTH];

  logic [NUM_DP-1:0] dp_accept;
  logic [PTR_W:0]    dp_num, rt_num, free_slots;
  logic [PTR_W-1:0]  dp_idx [NUM_DP];
  logic [PTR_W-1:0]  rt_idx [NUM_RT];
  logic [PTR_W-1:0]  wb_idx [NUM_WB];
  logic              head_block, wb_dup;

  // Pack each physical entry so a single rotator builds the age-ordered view.
  always_comb begin
    flat = '0;
    for (int j = 0; j < DEPTH; j++)
      flat[j*ENTRY_W +: ENTRY_W] = {flags_q[j], info_q[j], data_q[j]};
  end

  rvv_rob_age_rotate #(.DEPTH(DEPTH), .W(ENTRY_W)) u_rotate (
    .din   (flat),
    .shift (rptr_q[PTR_W-1:0]),
    .dout  (rot)
  );

  // Unpack the age-ordered view and drive the bypass outputs from it.
  always_comb begin
    byp_valid = '0;
    byp_done  = '0;
    byp_info  = '0;
    byp_data  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      {age_flags[j], age_info[j], age_data[j]} = rot[j*ENTRY_W +: ENTRY_W];
      byp_valid[j]              = age_flags[j].valid;
      byp_done[j]               = age_flags[j].done;
      byp_info[j*INFO_W +: INFO_W] = age_info[j];
      byp_data[j*DATA_W +: DATA_W] = age_data[j];
    end
  end

  // Occupancy and dispatch acceptance; a trapped head stalls allocation.
  always_comb begin
    count      = wptr_q - rptr_q;
    empty      = (count == '0);
    full       = (count == (PTR_W+1)'(DEPTH));
    free_slots = (PTR_W+1)'(DEPTH) - count;
    head_block = age_flags[0].valid & age_flags[0].trap;
    dp_ready   = '0;
    dp_index   = '0;
    for (int i = 0; i < NUM_DP; i++) begin
      dp_idx[i]   = wptr_q[PTR_W-1:0] + PTR_W'(i);
      dp_ready[i] = (int'(free_slots) > i) & ~head_block;
      dp_index[i*PTR_W +: PTR_W] = dp_idx[i];
    end
    dp_accept = dp_valid & dp_ready;
    dp_num    = (PTR_W+1)'(popcount(32'(dp_accept)));
  end

  // Retire offers chain from the head; a trapped entry only ever retires from slot 0.
  always_comb begin
    logic prev;
    rt_valid  = '0;
    rt_info   = '0;
    rt_wvalid = '0;
    rt_data   = '0;
    rt_sat    = '0;
    rt_trap   = '0;
    rt_valid[0] = age_flags[0].valid & (age_flags[0].done | age_flags[0].trap) & rt_ready[0];
    prev = rt_valid[0];
    for (int i = 1; i < NUM_RT; i++) begin
      rt_valid[i] = age_flags[i].valid & age_flags[i].done & ~age_flags[i].trap &
                    ~age_flags[i-1].trap & rt_ready[i] & prev;
      prev = rt_valid[i];
    end
    for (int i = 0; i < NUM_RT; i++) begin
      rt_idx[i]    = rptr_q[PTR_W-1:0] + PTR_W'(i);
      rt_info[i*INFO_W +: INFO_W] = age_info[i];
      rt_data[i*DATA_W +: DATA_W] = age_data[i];
      rt_wvalid[i] = age_flags[i].wvalid & age_flags[i].done;
      rt_sat[i]    = age_flags[i].sat;
      rt_trap[i]   = age_flags[i].trap;
    end
    flush  = rt_valid[0] & age_flags[0].trap;
    rt_num = (PTR_W+1)'(popcount(32'(rt_valid)));
  end

  // Decode writeback targets and detect two ports hitting the same entry.
  always_comb begin
    wb_dup = 1'b0;
    for (int k = 0; k < NUM_WB; k++) wb_idx[k] = wb_entry[k*PTR_W +: PTR_W];
    for (int a = 0; a < NUM_WB; a++)
      for (int b = a + 1; b < NUM_WB; b++)
        if (wb_valid[a] && wb_valid[b] && wb_idx[a] == wb_idx[b]) wb_dup = 1'b1;
  end

  assign err_stale_wb = err_q;

  // Entry status and pointers; pops are applied last so they override a same-cycle writeback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) flags_q[j] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      for (int j = 0; j < DEPTH; j++) begin
        flags_q[j].valid <= 1'b0;
        flags_q[j].done  <= 1'b0;
        flags_q[j].trap  <= 1'b0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      for (int i = 0; i < NUM_DP; i++)
        if (dp_accept[i]) begin
          flags_q[dp_idx[i]].valid <= 1'b1;
          flags_q[dp_idx[i]].done  <= 1'b0;
          flags_q[dp_idx[i]].trap  <= 1'b0;
        end
      for (int k = NUM_WB - 1; k >= 0; k--)
        if (wb_valid[k]) begin
          if (flags_q[wb_idx[k]].valid) begin
            flags_q[wb_idx[k]].done   <= 1'b1;
            flags_q[wb_idx[k]].wvalid <= wb_wvalid[k];
            flags_q[wb_idx[k]].sat    <= wb_sat[k];
          end else begin
            err_q <= 1'b1;
          end
        end
      if (trap_valid && flags_q[trap_entry].valid) flags_q[trap_entry].trap <= 1'b1;
      for (int i = 0; i < NUM_RT; i++)
        if (rt_valid[i]) begin
          flags_q[rt_idx[i]].valid <= 1'b0;
          flags_q[rt_idx[i]].done  <= 1'b0;
          flags_q[rt_idx[i]].trap  <= 1'b0;
        end
      wptr_q <= wptr_q + dp_num;
      rptr_q <= rptr_q + rt_num;
    end
  end

  // Payload storage; lowest-numbered writeback port wins because it is written last.
  always_ff @(posedge clk) begin
    if (!flush) begin
      for (int i = 0; i < NUM_DP; i++)
        if (dp_accept[i]) info_q[dp_idx[i]] <= dp_info[i*INFO_W +: INFO_W];
      for (int k = NUM_WB - 1; k >= 0; k--)
        if (wb_valid[k] && flags_q[wb_idx[k]].valid) data_q[wb_idx[k]] <= wb_data[k*DATA_W +: DATA_W];
    end
  end

  // Protocol checks on the dispatch prefix and duplicate writeback targets.
  always @(posedge clk) begin
    if (rst_n) begin
      assert ((dp_valid & (dp_valid + NUM_DP'(1))) == '0);
      assert (!wb_dup);
    end
  end

endmodule

// File: tb/tb_rvv_backend_rob_param.sv
// Directed, scoreboard-checked bench for the parametrised reorder buffer.
module tb_rvv_backend_rob_param;

  localparam int DEPTH = 8, NUM_DP = 2, NUM_WB = 9, NUM_RT = 4;
  localparam int DATA_W = 128, INFO_W = 32, PTR_W = 3;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic [NUM_DP-1:0]        dp_valid;
  logic [NUM_DP*INFO_W-1:0] dp_info;
  logic [NUM_DP-1:0]        dp_ready;
  logic [NUM_DP*PTR_W-1:0]  dp_index;
  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*PTR_W-1:0]  wb_entry;
  logic [NUM_WB-1:0]        wb_wvalid;
  logic [NUM_WB*DATA_W-1:0] wb_data;
  logic [NUM_WB-1:0]        wb_sat;
  logic [NUM_RT-1:0]        rt_valid;
  logic [NUM_RT-1:0]        rt_ready;
  logic [NUM_RT*INFO_W-1:0] rt_info;
  logic [NUM_RT-1:0]        rt_wvalid;
  logic [NUM_RT*DATA_W-1:0] rt_data;
  logic [NUM_RT-1:0]        rt_sat;
  logic [NUM_RT-1:0]        rt_trap;
  logic                     trap_valid;
  logic [PTR_W-1:0]         trap_entry;
  logic                     flush;
  logic [DEPTH-1:0]         byp_valid;
  logic [DEPTH-1:0]         byp_done;
  logic [DEPTH*INFO_W-1:0]  byp_info;
  logic [DEPTH*DATA_W-1:0]  byp_data;
  logic [PTR_W:0]           count;
  logic                     empty;
  logic                     full;
  logic                     err_stale_wb;

  always #5 clk = ~clk;

  rvv_backend_rob_param #(
    .DEPTH(DEPTH), .NUM_DP(NUM_DP), .NUM_WB(NUM_WB), .NUM_RT(NUM_RT),
    .DATA_W(DATA_W), .INFO_W(INFO_W)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .dp_valid(dp_valid), .dp_info(dp_info), .dp_ready(dp_ready), .dp_index(dp_index),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_wvalid(wb_wvalid), .wb_data(wb_data), .wb_sat(wb_sat),
    .rt_valid(rt_valid), .rt_ready(rt_ready), .rt_info(rt_info), .rt_wvalid(rt_wvalid),
    .rt_data(rt_data), .rt_sat(rt_sat), .rt_trap(rt_trap),
    .trap_valid(trap_valid), .trap_entry(trap_entry), .flush(flush),
    .byp_valid(byp_valid), .byp_done(byp_done), .byp_info(byp_info), .byp_data(byp_data),
    .count(count), .empty(empty), .full(full), .err_stale_wb(err_stale_wb)
  );

  typedef struct {
    logic [PTR_W-1:0]  entry;
    logic [INFO_W-1:0] info;
  } exp_t;

  exp_t              sbq[$];
  logic [DATA_W-1:0] mData  [DEPTH];
  logic [INFO_W-1:0] infoOf [DEPTH];
  logic              mTrap  [DEPTH];
  logic              mWv    [DEPTH];
  logic [PTR_W-1:0]  mWptr;
  int                nChecks = 0;
  int                nFails  = 0;

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    nChecks++;
    assert (observed === expected)
      else begin
        nFails++;
        $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
  endtask

  // Drive one dispatch beat; expected entries come from the bench's own write pointer.
  task automatic applyStimulus(input logic [NUM_DP-1:0] dpv, input logic [INFO_W-1:0] i0, input logic [INFO_W-1:0] i1);
    logic [PTR_W-1:0]  e;
    logic [INFO_W-1:0] inf;
    dp_valid = dpv;
    dp_info  = {i1, i0};
    #1;
    for (int i = 0; i < NUM_DP; i++) begin
      if (dpv[i]) begin
        e   = mWptr + PTR_W'(i);
        inf = (i == 0) ? i0 : i1;
        checkOutput("dp_ready", 128'(dp_ready[i]), 128'(1'b1));
        checkOutput("dp_index", 128'(dp_index[i*PTR_W +: PTR_W]), 128'(e));
        sbq.push_back('{entry: e, info: inf});
        infoOf[e] = inf;
        mTrap[e]  = 1'b0;
        mWv[e]    = 1'b0;
      end
    end
    mWptr = mWptr + PTR_W'(dpv[0]) + PTR_W'(dpv[1]);
  endtask

  task automatic doWb(input int port, input logic [PTR_W-1:0] e, input logic [DATA_W-1:0] d,
                      input logic wv, input logic model);
    wb_valid[port]                   = 1'b1;
    wb_entry[port*PTR_W +: PTR_W]    = e;
    wb_wvalid[port]                  = wv;
    wb_data[port*DATA_W +: DATA_W]   = d;
    wb_sat[port]                     = 1'b0;
    if (model) begin
      mData[e] = d;
      mWv[e]   = wv;
    end
  endtask

  // Retire monitor at the falling edge, then advance one cycle and drop pulsed inputs.
  task automatic tick();
    exp_t ex;
    @(negedge clk);
    for (int i = 0; i < NUM_RT; i++) begin
      if (rt_valid[i]) begin
        if (sbq.size() == 0) begin
          checkOutput("rt_unexpected", 128'(rt_valid[i]), 128'(1'b0));
        end else begin
          ex = sbq.pop_front();
          checkOutput("rt_info",   128'(rt_info[i*INFO_W +: INFO_W]), 128'(ex.info));
          checkOutput("rt_trap",   128'(rt_trap[i]),   128'(mTrap[ex.entry]));
          checkOutput("rt_wvalid", 128'(rt_wvalid[i]), 128'(mWv[ex.entry]));
          checkOutput("rt_data",   rt_data[i*DATA_W +: DATA_W], mData[ex.entry]);
        end
      end
    end
    if (flush) begin
      sbq.delete();
      mWptr = '0;
    end
    @(posedge clk);
    #1;
    dp_valid   = '0;
    wb_valid   = '0;
    trap_valid = 1'b0;
  endtask

  initial begin
    for (int j = 0; j < DEPTH; j++) begin
      mData[j] = '0; infoOf[j] = '0; mTrap[j] = 1'b0; mWv[j] = 1'b0;
    end
    mWptr = '0;
    rst_n = 1'b0;
    dp_valid = '0; dp_info = '0; wb_valid = '0; wb_entry = '0; wb_wvalid = '0;
    wb_data = '0; wb_sat = '0; rt_ready = '0; trap_valid = 1'b0; trap_entry = '0;
    #3;
    checkOutput("rst_count",   128'(count), 128'(0));
    checkOutput("rst_empty",   128'(empty), 128'(1'b1));
    checkOutput("rst_full",    128'(full),  128'(1'b0));
    checkOutput("rst_flush",   128'(flush), 128'(1'b0));
    checkOutput("rst_err",     128'(err_stale_wb), 128'(1'b0));
    checkOutput("rst_rtv",     128'(rt_valid),  128'(0));
    checkOutput("rst_bypv",    128'(byp_valid), 128'(0));
    checkOutput("rst_bypd",    128'(byp_done),  128'(0));
    checkOutput("rst_dpready", 128'(dp_ready),  128'(2'b11));
    checkOutput("rst_dpindex", 128'(dp_index),  128'(6'b001_000));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill all eight entries two at a time.
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 32'h100 + 32'(2*c), 32'h101 + 32'(2*c));
      tick();
    end
    checkOutput("fill_count", 128'(count), 128'(8));
    checkOutput("fill_full",  128'(full),  128'(1'b1));
    dp_valid = 2'b11;
    #1;
    checkOutput("fill_dpready", 128'(dp_ready),  128'(0));
    checkOutput("fill_bypv",    128'(byp_valid), 128'(8'hFF));
    checkOutput("fill_bypd",    128'(byp_done),  128'(0));
    tick();

    // Out-of-order completion, in-order retire.
    rt_ready = 4'hF;
    doWb(8, 3'd3, 128'hA3, 1'b1, 1'b1); tick();
    checkOutput("no_early_retire_a", 128'(rt_valid), 128'(0));
    doWb(3, 3'd1, 128'hA1, 1'b1, 1'b1); tick();
    checkOutput("no_early_retire_b", 128'(rt_valid), 128'(0));
    doWb(0, 3'd0, 128'hA0, 1'b1, 1'b1); tick();
    checkOutput("retire_01", 128'(rt_valid), 128'(4'b0011));
    doWb(5, 3'd2, 128'hA2, 1'b0, 1'b1); tick();
    checkOutput("retire_23", 128'(rt_valid), 128'(4'b0011));
    tick();
    rt_ready = '0;
    checkOutput("after_retire_count", 128'(count), 128'(4));

    // Trap on the third of four completed entries.
    for (int p = 0; p < 4; p++) doWb(p, PTR_W'(4 + p), 128'hB0 + 128'(p), 1'b1, 1'b1);
    tick();
    trap_valid = 1'b1; trap_entry = 3'd6; mTrap[6] = 1'b1;
    tick();
    rt_ready = 4'hF;
    #1;
    checkOutput("trap_rtv",   128'(rt_valid), 128'(4'b0011));
    checkOutput("trap_noflush", 128'(flush),  128'(1'b0));
    tick();
    checkOutput("trap_head_rtv",  128'(rt_valid),   128'(4'b0001));
    checkOutput("trap_head_trap", 128'(rt_trap[0]), 128'(1'b1));
    checkOutput("trap_flush",     128'(flush),      128'(1'b1));
    doWb(1, 3'd7, 128'hEE, 1'b1, 1'b0);
    tick();
    checkOutput("post_flush_count", 128'(count), 128'(0));
    checkOutput("post_flush_empty", 128'(empty), 128'(1'b1));
    checkOutput("post_flush_idx0",  128'(dp_index[PTR_W-1:0]), 128'(0));
    checkOutput("post_flush_bypv",  128'(byp_valid), 128'(0));
    checkOutput("post_flush_err",   128'(err_stale_wb), 128'(1'b0));

    // Writeback into an empty entry is dropped and flagged.
    doWb(2, 3'd5, 128'hCC, 1'b1, 1'b0);
    tick();
    checkOutput("stale_err",  128'(err_stale_wb), 128'(1'b1));
    checkOutput("stale_bypd", 128'(byp_done), 128'(0));
    checkOutput("stale_count", 128'(count), 128'(0));

    // Wrap-around: retire six, then allocate six past index 7.
    rt_ready = '0;
    for (int c = 0; c < 4; c++) begin
      applyStimulus(2'b11, 32'h200 + 32'(2*c), 32'h201 + 32'(2*c));
      tick();
    end
    for (int p = 0; p < 8; p++) doWb(p, PTR_W'(p), 128'h2000 + 128'(p), 1'b1, 1'b1);
    tick();
    rt_ready = 4'hF;   tick();
    rt_ready = 4'b0011; tick();
    rt_ready = '0;
    checkOutput("wrap_count", 128'(count), 128'(2));
    checkOutput("wrap_bypv",  128'(byp_valid), 128'(8'b0000_0011));
    checkOutput("wrap_bypd",  128'(byp_done),  128'(8'b0000_0011));
    checkOutput("wrap_bypi0", 128'(byp_info[0 +: INFO_W]), 128'(infoOf[6]));
    checkOutput("wrap_bypd0", byp_data[0 +: DATA_W], mData[6]);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b11, 32'h300 + 32'(2*c), 32'h301 + 32'(2*c));
      tick();
    end
    checkOutput("wrap_full",   128'(full),  128'(1'b1));
    checkOutput("wrap_count8", 128'(count), 128'(8));
    checkOutput("wrap_bypv8",  128'(byp_valid), 128'(8'hFF));
    checkOutput("wrap_bypi2",  128'(byp_info[2*INFO_W +: INFO_W]), 128'(32'h300));
    for (int p = 0; p < 6; p++) doWb(p, PTR_W'(p), 128'h3000 + 128'(p), 1'b1, 1'b1);
    rt_ready = 4'hF;
    for (int c = 0; c < 20 && sbq.size() != 0; c++) tick();
    checkOutput("drain", 128'(sbq.size()), 128'(0));
    checkOutput("drain_empty", 128'(empty), 128'(1'b1));

    // Asynchronous reset while a flush is pending.
    rt_ready = '0;
    applyStimulus(2'b11, 32'h400, 32'h401);
    tick();
    trap_valid = 1'b1; trap_entry = 3'd6; mTrap[6] = 1'b1;
    tick();
    rt_ready = 4'hF;
    #1;
    checkOutput("pend_flush", 128'(flush), 128'(1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_count",   128'(count), 128'(0));
    checkOutput("arst_empty",   128'(empty), 128'(1'b1));
    checkOutput("arst_flush",   128'(flush), 128'(1'b0));
    checkOutput("arst_err",     128'(err_stale_wb), 128'(1'b0));
    checkOutput("arst_rtv",     128'(rt_valid),  128'(0));
    checkOutput("arst_bypv",    128'(byp_valid), 128'(0));
    checkOutput("arst_dpready", 128'(dp_ready),  128'(2'b11));
    checkOutput("arst_dpindex", 128'(dp_index),  128'(6'b001_000));
    sbq.delete();
    mWptr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < 3; c++) begin
      checkOutput("no_retire_after_reset", 128'(rt_valid), 128'(0));
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
